mcp4922_rx: RTL and testbench
=============================

Name: mcp4922_rx

Overview:
SPI responder that emulates the input side of an MCP4922 dual 12-bit DAC inside the FPGA. It captures 16-bit write frames from an SPI master, holds them in per-channel input registers, and transfers them to output registers on an LDAC falling edge. It is used as a bench/loopback target for the DAC driver and as a digital DAC substitute feeding internal vector-display logic.

Parameters:
SYNC_STAGES, 2, flip-flop stages on each asynchronous SPI input (minimum 2).
RESET_CODE, 12'h000, reset value of the input and output data registers.

Ports:
I_clk  input  1  system clock (27 MHz); must be at least 4x the SCLK frequency.
I_reset  input  1  synchronous active-high reset.
I_sclk  input  1  SPI clock from master; asynchronous to I_clk.
I_sd  input  1  serial data, MSB first, sampled on SCLK rising edge.
I_cs_n  input  1  chip select, active low; one frame per low period.
I_ldac_n  input  1  latch DAC; falling edge transfers input registers to outputs.
O_dataA  output  12  channel A output code.
O_dataB  output  12  channel B output code.
O_cfgA  output  3  channel A {BUF, GA_n, SHDN_n}, latched with O_dataA.
O_cfgB  output  3  channel B {BUF, GA_n, SHDN_n}, latched with O_dataB.
O_frame_valid  output  1  one-cycle pulse when a 16-bit frame is accepted.
O_frame_err  output  1  one-cycle pulse when a frame is discarded.
O_update  output  1  one-cycle pulse when outputs are loaded from the input registers.

Behaviour:
- Reset: O_dataA/B = RESET_CODE; O_cfgA/B = 3'b011 (unbuffered, gain 1x, active); all pulses 0; internal input registers equal to their output counterparts; bit counter 0; state IDLE.
- I_sclk, I_cs_n, I_ldac_n and I_sd each pass through SYNC_STAGES flops. I_sd is delayed by the same number of stages so it stays aligned with SCLK.
- Edge detection compares the last two synchronized samples. Inputs-to-decision latency is SYNC_STAGES+1 I_clk cycles.
- FSM IDLE: on a cs_n falling edge, clear the shift register and the 5-bit bit counter, then go to SHIFT.
- FSM SHIFT: on each sclk rising edge while cs_n is low, shift in sd (MSB first) and increment the counter. The counter saturates at 17.
- FSM SHIFT, cs_n rising edge, go to COMMIT.
- FSM COMMIT (one cycle), count == 16: bit 15 selects the channel (0 = A, 1 = B). Bits 14:12 go to that channel's input cfg register and bits 11:0 to its input data register. Pulse O_frame_valid. Return to IDLE.
- FSM COMMIT, count == 0: no action, no pulse. Return to IDLE.
- FSM COMMIT, any other count: discard the frame, leave the input registers unchanged, pulse O_frame_err. Return to IDLE.
- LDAC: on a synchronized ldac_n falling edge, copy both input registers (data and cfg) to the outputs on the next cycle and pulse O_update. Every ldac_n falling edge reloads the outputs, even when no new frame has arrived.
- Simultaneous COMMIT and ldac_n falling edge: the commit is applied first, so the transfer carries the new frame.
- Outputs never change except on a transfer.
- cs_n falling edge while in SHIFT (glitch): restart the frame and do not flag an error.
- Reset mid-frame: the partial frame is lost, with no error pulse.

Optional Feature:
MCP4922_RX_VOUT_EN
- Defined: adds ports O_voutA and O_voutB (output, 13 bits each) holding the modelled analogue code.
- Each vout is 0 when SHDN_n = 0, {1'b0, data} when GA_n = 1, and {data, 1'b0} (2x gain) when GA_n = 0.
- Each vout is registered and updates one cycle after the corresponding output register changes. Reset value is 0.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package mcp4922_pkg: FRAME_BITS = 16; bit positions AB = 15, BUF = 14, GA_N = 13, SHDN_N = 12, DATA = 11:0; CFG_RESET = 3'b011; FSM state encoding IDLE/SHIFT/COMMIT.
- One sub-module, sync_edge: SYNC_STAGES synchronizer plus rise/fall pulse outputs. Instantiated for sclk, cs_n and ldac_n; the sd path uses its synchronized output only.

Test Plan:
- Frame 16'h3ABC, then 16'hB123, then an LDAC low pulse: O_dataA = 12'hABC, O_dataB = 12'h123, O_cfgA = O_cfgB = 3'b011; two O_frame_valid pulses and one O_update pulse.
- Frame 16'h3555 with no LDAC: outputs stay at reset values. A later LDAC pulse yields O_dataA = 12'h555.
- 15-bit frame and 17-bit frame: one O_frame_err pulse each, no valid pulse; a following LDAC reproduces the prior values.
- I_reset asserted after 8 bits of a frame, then a clean frame 16'h3001 and LDAC: no error pulse, O_dataA = 12'h001.
- ldac_n falling edge aligned to the COMMIT cycle of frame 16'hB7FF: O_dataB = 12'h7FF in the same transfer, with one O_update pulse.
- MCP4922_RX_VOUT_EN: frame 16'h1800 then LDAC gives O_voutA = 13'h1000 (GA_n = 0). Frame 16'h2800 then LDAC gives O_voutA = 0 (SHDN_n = 0).

Source files
------------

// File: rtl/mcp4922_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mcp4922_pkg
//  Description : Shared constants, frame bit positions and FSM encoding for
//                the MCP4922 SPI input emulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package mcp4922_pkg;

  localparam int FRAME_BITS = 16;

  // Bit positions inside a 16-bit write frame
  localparam int AB       = 15;
  localparam int BUF      = 14;
  localparam int GA_N     = 13;
  localparam int SHDN_N   = 12;
  localparam int DATA_MSB = 11;
  localparam int DATA_LSB = 0;

  // Cfg reset: unbuffered, gain 1x, active ({BUF, GA_n, SHDN_n})
  localparam logic [2:0] CFG_RESET = 3'b011;

  // Bit counter saturates one past a full frame so overlong frames are caught
  localparam logic [4:0] CNT_MAX  = 5'd17;
  localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Modelled analogue code: cfg is {BUF, GA_n, SHDN_n}
  function automatic logic [12:0] vout_code(input logic [11:0] data,
                                            input logic [2:0]  cfg);
    logic [12:0] code;
    if (!cfg[SHDN_N - SHDN_N])      code = 13'd0;
    else if (cfg[GA_N - SHDN_N])    code = {1'b0, data};
    else                            code = {data, 1'b0};
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mcp4922_rx_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge
//  Description : Multi-stage synchronizer for one asynchronous input with
//                rise/fall pulses derived from the last two synced samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Next values: shift the raw input down the chain, remember the last sample
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_async};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer chain and edge-history register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_sync = sync_q[SYNC_STAGES-1];
  assign o_rise =  sync_q[SYNC_STAGES-1] & ~prev_q;
  assign o_fall = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule
`default_nettype wire

// File: rtl/mcp4922_rx.sv
`default_nettype none
// ============================================================================
//  Module      : mcp4922_rx
//  Description : SPI responder emulating the MCP4922 dual 12-bit DAC input
//                side: frame capture, per-channel input registers and an
//                LDAC-triggered transfer to the output registers.
//  Options     : MCP4922_RX_VOUT_EN adds O_voutA/O_voutB modelled codes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mcp4922_rx
  import mcp4922_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [11:0] RESET_CODE  = 12'h000
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_sclk,
  input  logic        I_sd,
  input  logic        I_cs_n,
  input  logic        I_ldac_n,
  output logic [11:0] O_dataA,
  output logic [11:0] O_dataB,
  output logic [2:0]  O_cfgA,
  output logic [2:0]  O_cfgB,
`ifdef MCP4922_RX_VOUT_EN
  output logic [12:0] O_voutA,
  output logic [12:0] O_voutB,
`endif
  output logic        O_frame_valid,
  output logic        O_frame_err,
  output logic        O_update
);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic ldac_sync, ldac_rise, ldac_fall;
  logic sd_sync, sd_rise, sd_fall;
  logic unused_sync;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
    .i_clk(I_clk), .i_rst(I_reset), .i_async(I_sclk),
    .o_sync(sclk_sync), .o_rise(sclk_rise), .o_fall(sclk_fall));

  // Deselected / inactive at reset so a released reset does not fake an edge
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
    .i_clk(I_clk), .i_rst(I_reset), .i_async(I_cs_n),
    .o_sync(cs_sync), .o_rise(cs_rise), .o_fall(cs_fall));

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ldac (
    .i_clk(I_clk), .i_rst(I_reset), .i_async(I_ldac_n),
    .o_sync(ldac_sync), .o_rise(ldac_rise), .o_fall(ldac_fall));

  // Same depth as the SCLK path so data stays aligned with the sampling edge
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sd (
    .i_clk(I_clk), .i_rst(I_reset), .i_async(I_sd),
    .o_sync(sd_sync), .o_rise(sd_rise), .o_fall(sd_fall));

  assign unused_sync = ^{sclk_sync, sclk_fall, ldac_sync, ldac_rise, sd_rise, sd_fall};

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [15:0] shreg_q, shreg_d;
  logic [11:0] in_data_a_q, in_data_a_d, in_data_b_q, in_data_b_d;
  logic [2:0]  in_cfg_a_q, in_cfg_a_d, in_cfg_b_q, in_cfg_b_d;
  logic [11:0] out_data_a_q, out_data_a_d, out_data_b_q, out_data_b_d;
  logic [2:0]  out_cfg_a_q, out_cfg_a_d, out_cfg_b_q, out_cfg_b_d;
  logic        frame_valid_q, frame_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        update_q, update_d;

  // Frame FSM, input-register commit and LDAC transfer (commit feeds transfer)
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    shreg_d       = shreg_q;
    in_data_a_d   = in_data_a_q;
    in_data_b_d   = in_data_b_q;
    in_cfg_a_d    = in_cfg_a_q;
    in_cfg_b_d    = in_cfg_b_q;
    out_data_a_d  = out_data_a_q;
    out_data_b_d  = out_data_b_q;
    out_cfg_a_d   = out_cfg_a_q;
    out_cfg_b_d   = out_cfg_b_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    update_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          shreg_d = '0;
          count_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_fall) begin
          // Chip-select glitch: silently restart the frame
          shreg_d = '0;
          count_d = '0;
        end else if (cs_rise) begin
          state_d = COMMIT;
        end else if (sclk_rise && !cs_sync) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], sd_sync};
          if (count_q != CNT_MAX) count_d = count_q + 5'd1;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (count_q == CNT_FULL) begin
          if (shreg_q[AB]) begin
            in_cfg_b_d  = shreg_q[BUF:SHDN_N];
            in_data_b_d = shreg_q[DATA_MSB:DATA_LSB];
          end else begin
            in_cfg_a_d  = shreg_q[BUF:SHDN_N];
            in_data_a_d = shreg_q[DATA_MSB:DATA_LSB];
          end
          frame_valid_d = 1'b1;
        end else if (count_q != 5'd0) begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (ldac_fall) begin
      out_data_a_d = in_data_a_d;
      out_data_b_d = in_data_b_d;
      out_cfg_a_d  = in_cfg_a_d;
      out_cfg_b_d  = in_cfg_b_d;
      update_d     = 1'b1;
    end
  end

  // State, data and pulse registers
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      shreg_q       <= '0;
      in_data_a_q   <= RESET_CODE;
      in_data_b_q   <= RESET_CODE;
      in_cfg_a_q    <= CFG_RESET;
      in_cfg_b_q    <= CFG_RESET;
      out_data_a_q  <= RESET_CODE;
      out_data_b_q  <= RESET_CODE;
      out_cfg_a_q   <= CFG_RESET;
      out_cfg_b_q   <= CFG_RESET;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      update_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      shreg_q       <= shreg_d;
      in_data_a_q   <= in_data_a_d;
      in_data_b_q   <= in_data_b_d;
      in_cfg_a_q    <= in_cfg_a_d;
      in_cfg_b_q    <= in_cfg_b_d;
      out_data_a_q  <= out_data_a_d;
      out_data_b_q  <= out_data_b_d;
      out_cfg_a_q   <= out_cfg_a_d;
      out_cfg_b_q   <= out_cfg_b_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      update_q      <= update_d;
    end
  end

  assign O_dataA       = out_data_a_q;
  assign O_dataB       = out_data_b_q;
  assign O_cfgA        = out_cfg_a_q;
  assign O_cfgB        = out_cfg_b_q;
  assign O_frame_valid = frame_valid_q;
  assign O_frame_err   = frame_err_q;
  assign O_update      = update_q;

`ifdef MCP4922_RX_VOUT_EN
  logic [12:0] vout_a_q, vout_a_d, vout_b_q, vout_b_d;

  // Modelled analogue code follows the output registers one cycle later
  always_comb begin
    vout_a_d = vout_code(out_data_a_q, out_cfg_a_q);
    vout_b_d = vout_code(out_data_b_q, out_cfg_b_q);
  end

  // Analogue code registers
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      vout_a_q <= '0;
      vout_b_q <= '0;
    end else begin
      vout_a_q <= vout_a_d;
      vout_b_q <= vout_b_d;
    end
  end

  assign O_voutA = vout_a_q;
  assign O_voutB = vout_b_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mcp4922_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcp4922_rx
//  Description : Directed self-checking bench for mcp4922_rx.
//  Options     : MCP4922_RX_VOUT_EN enables the O_voutA/O_voutB checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mcp4922_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        sd = 1'b0;
  logic        cs_n = 1'b1;
  logic        ldac_n = 1'b1;
  logic [11:0] data_a, data_b;
  logic [2:0]  cfg_a, cfg_b;
  logic        frame_valid, frame_err, update;
`ifdef MCP4922_RX_VOUT_EN
  logic [12:0] vout_a, vout_b;
`endif

  int vectors = 0;
  int miscompares = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_update = 0;
  int v0, e0, u0;

  always #5 clk = ~clk;

  mcp4922_rx #(.SYNC_STAGES(2), .RESET_CODE(12'h000)) dut (
    .I_clk(clk), .I_reset(rst), .I_sclk(sclk), .I_sd(sd), .I_cs_n(cs_n),
    .I_ldac_n(ldac_n),
    .O_dataA(data_a), .O_dataB(data_b), .O_cfgA(cfg_a), .O_cfgB(cfg_b),
`ifdef MCP4922_RX_VOUT_EN
    .O_voutA(vout_a), .O_voutB(vout_b),
`endif
    .O_frame_valid(frame_valid), .O_frame_err(frame_err), .O_update(update));

  always @(negedge clk) begin
    if (frame_valid) n_valid  <= n_valid + 1;
    if (frame_err)   n_err    <= n_err + 1;
    if (update)      n_update <= n_update + 1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    wait_clks(1);
    v0 = n_valid; e0 = n_err; u0 = n_update;
  endtask

  // Shift nbits of d, MSB first; SCLK period is 8 system clocks
  task automatic send_bits(input logic [16:0] d, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      sd = d[i];
      wait_clks(4);
      sclk = 1'b1;
      wait_clks(4);
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [16:0] d, input int nbits);
    cs_n = 1'b0;
    wait_clks(4);
    send_bits(d, nbits);
    wait_clks(4);
    cs_n = 1'b1;
    wait_clks(8);
  endtask

  task automatic ldac_pulse();
    ldac_n = 1'b0;
    wait_clks(4);
    ldac_n = 1'b1;
    wait_clks(6);
  endtask

  initial begin
    // Reset state
    wait_clks(5);
    check("rst_frame_valid", {15'd0, frame_valid}, 16'd0);
    check("rst_frame_err",   {15'd0, frame_err},   16'd0);
    check("rst_update",      {15'd0, update},      16'd0);
    rst = 1'b0;
    wait_clks(6);
    check("rst_dataA", {4'd0, data_a}, 16'h000);
    check("rst_dataB", {4'd0, data_b}, 16'h000);
    check("rst_cfgA",  {13'd0, cfg_a}, 16'h003);
    check("rst_cfgB",  {13'd0, cfg_b}, 16'h003);
`ifdef MCP4922_RX_VOUT_EN
    check("rst_voutA", {3'd0, vout_a}, 16'h0000);
`endif

    // Frame without LDAC leaves outputs alone; later LDAC loads it
    snap();
    send_frame(17'h03555, 16);
    check("nold_dataA", {4'd0, data_a}, 16'h000);
    check("nold_valid", 16'(n_valid - v0), 16'd1);
    check("nold_update", 16'(n_update - u0), 16'd0);
    ldac_pulse();
    check("ld555_dataA", {4'd0, data_a}, 16'h555);
    check("ld555_update", 16'(n_update - u0), 16'd1);

    // Two channels then one LDAC
    snap();
    send_frame(17'h03ABC, 16);
    send_frame(17'h0B123, 16);
    ldac_pulse();
    check("ab_dataA", {4'd0, data_a}, 16'hABC);
    check("ab_dataB", {4'd0, data_b}, 16'h123);
    check("ab_cfgA",  {13'd0, cfg_a}, 16'h003);
    check("ab_cfgB",  {13'd0, cfg_b}, 16'h003);
    check("ab_valid", 16'(n_valid - v0), 16'd2);
    check("ab_update", 16'(n_update - u0), 16'd1);

    // Short and long frames are discarded
    snap();
    send_frame(17'h00FFF, 15);
    check("short_err", 16'(n_err - e0), 16'd1);
    send_frame(17'h13FFF, 17);
    check("long_err", 16'(n_err - e0), 16'd2);
    check("badlen_valid", 16'(n_valid - v0), 16'd0);
    ldac_pulse();
    check("badlen_dataA", {4'd0, data_a}, 16'hABC);
    check("badlen_dataB", {4'd0, data_b}, 16'h123);
    check("badlen_update", 16'(n_update - u0), 16'd1);

    // Reset after 8 bits of a frame
    snap();
    cs_n = 1'b0;
    wait_clks(4);
    send_bits(17'h0FF, 8);
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(4);
    cs_n = 1'b1;
    wait_clks(8);
    send_frame(17'h03001, 16);
    ldac_pulse();
    check("midrst_err", 16'(n_err - e0), 16'd0);
    check("midrst_dataA", {4'd0, data_a}, 16'h001);
    check("midrst_dataB", {4'd0, data_b}, 16'h000);

    // LDAC falling edge lands on the COMMIT cycle
    snap();
    cs_n = 1'b0;
    wait_clks(4);
    send_bits(17'h0B7FF, 16);
    wait_clks(4);
    cs_n = 1'b1;
    wait_clks(1);
    ldac_n = 1'b0;
    wait_clks(4);
    ldac_n = 1'b1;
    wait_clks(8);
    check("align_dataB", {4'd0, data_b}, 16'h7FF);
    check("align_valid", 16'(n_valid - v0), 16'd1);
    check("align_update", 16'(n_update - u0), 16'd1);

`ifdef MCP4922_RX_VOUT_EN
    send_frame(17'h01800, 16);
    ldac_pulse();
    check("vout_gain2", {3'd0, vout_a}, 16'h1000);
    check("vout_cfgA", {13'd0, cfg_a}, 16'h001);
    send_frame(17'h02800, 16);
    ldac_pulse();
    check("vout_shdn", {3'd0, vout_a}, 16'h0000);
    check("vout_B", {3'd0, vout_b}, 16'h07FF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
